seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse operation of the combinational multiplier blocks.
- Takes a WIDTH-bit dividend and divisor and produces quotient and remainder.
- Retires one quotient bit per clock, using start/done handshaking.
- Used wherever a product must be decomposed back into factors, or for ratio and scale computation, without a large combinational array.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request a division; sampled on rising edge
dividend  input  WIDTH  numerator; captured on the accepted start edge
divisor  input  WIDTH  denominator; captured on the accepted start edge
busy  output  1  high while iterating (CALC state)
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  set with done when the captured divisor was 0

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: on any rising edge with rst_n=0, the following happen regardless of state or other inputs, including mid-operation:
  - state goes to IDLE
  - busy, done, quotient, remainder and div_by_zero go to 0
  - internal shift registers and iteration counter clear
- States: IDLE, CALC, DONE.
- Start acceptance:
  - start=1 is accepted only in IDLE or DONE.
  - start in CALC is ignored: no operand capture, no effect on the current operation.
- Accepted start, divisor != 0 (edge k):
  - capture dividend into quotient shift register Q and divisor into D
  - clear partial remainder R (WIDTH+1 bits)
  - count=0
  - go to CALC; busy=1 from edge k
- CALC, one step per edge:
  - R_shift = {R[WIDTH-1:0], Q[WIDTH-1]}
  - Q shifts left one place
  - if R_shift >= {1'b0,D}: R = R_shift - D and new Q[0]=1
  - else: R = R_shift and new Q[0]=0
  - count increments
- CALC exit:
  - On the edge performing step WIDTH (edge k+WIDTH), load quotient=final Q and remainder=final R[WIDTH-1:0], div_by_zero=0, and go to DONE.
  - busy=0 and done=1 during the cycle after edge k+WIDTH.
  - Latency from accepting start to done is therefore WIDTH cycles.
- Accepted start, divisor == 0 (edge k):
  - no iteration; go directly to DONE
  - quotient=all ones (2^WIDTH-1), remainder=dividend, div_by_zero=1
  - done=1 during the cycle after edge k (latency 1)
- DONE:
  - lasts exactly one cycle; the next edge returns to IDLE with done=0 unless start=1, in which case a new operation is accepted on that same edge.
  - back-to-back operations are therefore legal with no idle gap.
- Output hold:
  - quotient, remainder and div_by_zero hold their last values through IDLE and CALC until the next result load.
  - they are not cleared by a new start; only reset clears them.
- Invariants:
  - done and busy are never high simultaneously.
  - for every divisor != 0: quotient*divisor + remainder == dividend and remainder < divisor.
- Arithmetic: unsigned only. No overflow is possible, because quotient <= dividend fits in WIDTH bits.
- Inputs dividend and divisor may change freely after the start edge; only the captured copies are used.

Test Plan:
- Basic division, WIDTH=4: rst_n low for 2 edges, then start with 13/3 → busy for 4 cycles, done pulse 4 cycles after start, quotient=4, remainder=1, div_by_zero=0.
- Edge values: 15/1 → q=15, r=0. 2/7 → q=0, r=2. 0/5 → q=0, r=0. 15/15 → q=1, r=0. Each completes with done at latency 4.
- Divide by zero: 9/0 → done 1 cycle after start, quotient=15, remainder=9, div_by_zero=1. A following 8/2 → q=4, r=0, div_by_zero=0.
- Start during busy: start 14/4, then pulse start with 3/1 two cycles later → ignored; result q=3, r=2 at latency 4, with exactly one done pulse.
- Back-to-back and reset: assert start with 10/3 in the DONE cycle of a prior 7/2 → first result q=3, r=1, then q=3, r=1 exactly 4 cycles later. Drop rst_n mid-CALC of another division → all outputs 0, no done pulse, IDLE; a subsequent 6/4 → q=1, r=2.
- Exhaustive sweep, WIDTH=4: all 256 dividend/divisor pairs → each matches the reference model (q, r, div_by_zero) with the correct latency.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero short-circuits to an all-ones quotient with the dividend as remainder.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold last values
// CALC  | iterating, one restoring step per clock (busy=1)
// DONE  | one-cycle result pulse (done=1); start may launch the next operation
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] r_sel;
  logic [WIDTH-1:0] q_next;

  // The partial remainder is always < D after a step, so WIDTH bits of storage suffice;
  // the borrow out of the (WIDTH+1)-bit subtraction is exactly the R_shift < D test.
  assign r_shift = {r_reg, q_sh[WIDTH-1]};
  assign diff    = r_shift - {1'b0, d_reg};
  assign ge      = ~diff[WIDTH];
  assign r_sel   = ge ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign q_next  = {q_sh[WIDTH-2:0], ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_sh        <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          q_sh  <= q_next;
          r_reg <= r_sel;
          count <= count + CW'(1);
          if (count == LAST_STEP) begin
            quotient    <= q_next;
            remainder   <= r_sel;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          if (start) begin
            if (divisor != '0) begin
              q_sh  <= dividend;
              d_reg <= divisor;
              r_reg <= '0;
              count <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks for seq_divider at WIDTH=4.
// Latency is counted in clock edges after the edge that accepts start.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] last_q  = '0;
  logic [W-1:0] last_r  = '0;
  logic         last_dz = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one operation and returns in the DONE cycle (or after the timeout).
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input string tag);
    int lat;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    if (b != '0) begin
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      check({tag, " hold_q"}, 32'(quotient), 32'(last_q));
      check({tag, " hold_r"}, 32'(remainder), 32'(last_r));
      check({tag, " hold_dz"}, 32'(div_by_zero), 32'(last_dz));
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      check({tag, " busy_done_overlap"}, 32'(busy & done), 32'd0);
    end
    check({tag, " latency"}, 32'(lat), (b == '0) ? 32'd0 : 32'(W));
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    last_q  = eq;
    last_r  = er;
    last_dz = edz;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n_done;
    int first_done;
    logic [W-1:0] mq, mr;
    logic mdz;

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
    vecs[2] = '{a: 4'd2,  b: 4'd7,  q: 4'd0,  r: 4'd2, dz: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1};
    vecs[6] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, dz: 1'b0};
    vecs[7] = '{a: 4'd12, b: 4'd5,  q: 4'd2,  r: 4'd2, dz: 1'b0};
    vecs[8] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, dz: 1'b1};

    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 4'd5;
    divisor  = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, $sformatf("vec%0d", i));
      idle_check($sformatf("vec%0d", i));
    end

    // start pulsed while CALC is running must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    first_done = -1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        start = 1'b1; dividend = 4'd3; divisor = 4'd1;
      end
      @(posedge clk);
      #1;
      if (i == 3) start = 1'b0;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
    end
    check("busy_start done_count", 32'(n_done), 32'd1);
    check("busy_start latency", 32'(first_done), 32'd4);
    check("busy_start quotient", 32'(quotient), 32'd3);
    check("busy_start remainder", 32'(remainder), 32'd2);
    last_q = 4'd3; last_r = 4'd2; last_dz = 1'b0;

    // back-to-back: second start lands in the DONE cycle of the first
    do_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, "b2b_first");
    do_div(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, "b2b_second");
    idle_check("b2b");

    // reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset quotient", 32'(quotient), 32'd0);
    check("midreset remainder", 32'(remainder), 32'd0);
    check("midreset div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    check("midreset no_activity", 32'(n_done), 32'd0);
    do_div(4'd6, 4'd4, 4'd1, 4'd2, 1'b0, "after_reset");
    idle_check("after_reset");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = '1; mr = W'(a); mdz = 1'b1;
        end else begin
          mq = W'(a / b); mr = W'(a % b); mdz = 1'b0;
        end
        do_div(W'(a), W'(b), mq, mr, mdz, $sformatf("sweep %0d/%0d", a, b));
        idle_check($sformatf("sweep %0d/%0d", a, b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
